// File: rtl/random_sample_fifo.sv
// ============================================================================
//  Module   : random_sample_fifo
//  Purpose  : First-word-fall-through sample FIFO between the free-running
//             range-filtered LFSR generator and an intermittent consumer.
//             Optional drop counter: RANDOM_SAMPLE_FIFO_DROP_COUNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module random_sample_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              capture_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
`ifdef RANDOM_SAMPLE_FIFO_DROP_COUNT_EN
  ,
  output logic [DROP_W-1:0] drop_cnt
`endif
);

  localparam logic [ADDR_W:0]   c_depth    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   c_cnt_one  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] c_ptr_one  = ADDR_W'(1);

  if ((DEPTH < 2) || (DEPTH != (1 << ADDR_W)) || (DROP_W < 1)) begin : g_param_check
    $error("random_sample_fifo: DEPTH must be 2**ADDR_W (>=2) and DROP_W >= 1");
  end

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_out_valid;

  logic              w_pop;
  logic              w_push;
  logic [ADDR_W:0]   w_count_nxt;

  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  assign w_pop  = r_out_valid & out_ready;
  assign w_push = in_valid & capture_en & (~r_full | w_pop);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + c_cnt_one;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - c_cnt_one;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == c_depth);
      r_empty     <= (w_count_nxt == '0);
      r_out_valid <= (w_count_nxt != '0);
    end
  end

  // Storage is deliberately left unreset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  assign out_data  = r_out_valid ? r_mem[r_rd_ptr] : '0;
  assign out_valid = r_out_valid;
  assign count     = r_count;
  assign full      = r_full;
  assign empty     = r_empty;

`ifdef RANDOM_SAMPLE_FIFO_DROP_COUNT_EN
  localparam logic [DROP_W-1:0] c_drop_max = '1;
  localparam logic [DROP_W-1:0] c_drop_one = DROP_W'(1);

  logic [DROP_W-1:0] r_drop_cnt;
  logic              w_drop;

  assign w_drop = in_valid & capture_en & r_full & ~w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != c_drop_max)) begin
      r_drop_cnt <= r_drop_cnt + c_drop_one;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

`default_nettype wire
